// File: rtl/cp0_unit.sv
// Coprocessor-0: status/cause/EPC/PRId registers, exception and interrupt
// request generation, and the mfc0 read mux for the M-stage pipeline.
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h0000_2024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] pc_in,
    input  logic        bd_in,
    input  logic [4:0]  excCode_in,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        req,
    output logic [31:0] EPC_out,
    output logic [31:0] DOut
);

    logic [5:0]  im_q,  im_d;
    logic        exl_q, exl_d;
    logic        ie_q,  ie_d;
    logic        bd_q,  bd_d;
    logic [5:0]  ip_q,  ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req_s;
    logic        exc_req_s;
    logic [31:0] sr_s;
    logic [31:0] cause_s;

    assign int_req_s = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign exc_req_s = (excCode_in != 5'd0) & ~exl_q;
    // Gated by reset so a pending excCode cannot flush the pipe while reset is held.
    assign req       = (int_req_s | exc_req_s) & ~reset;

    assign sr_s    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    assign cause_s = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0};
    assign EPC_out = epc_q;

    // Read mux for mfc0; no bypass of a same-cycle mtc0.
    always_comb begin
        DOut = 32'd0;
        case (A1)
            5'd12:   DOut = sr_s;
            5'd13:   DOut = cause_s;
            5'd14:   DOut = epc_q;
            5'd15:   DOut = PRID;
            default: DOut = 32'd0;
        endcase
    end

    // Next-state: a taken request overrides mtc0 because the writer is the flushed victim.
    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        exc_d = exc_q;
        epc_d = epc_q;
        ip_d  = HWInt;
        if (req) begin
            exl_d = 1'b1;
            bd_d  = bd_in;
            exc_d = int_req_s ? 5'd0 : excCode_in;
            epc_d = bd_in ? (pc_in - 32'd4) : pc_in;
        end else begin
            if (WE) begin
                case (A2)
                    5'd12: begin
                        im_d  = DIn[15:10];
                        exl_d = DIn[1];
                        ie_d  = DIn[0];
                    end
                    5'd14:   epc_d = DIn;
                    default: epc_d = epc_q;
                endcase
            end else begin
                epc_d = epc_q;
            end
            // eret clear is applied last so it beats an SR write of EXL.
            if (EXLClr) begin
                exl_d = 1'b0;
            end else begin
                exl_d = exl_d;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q  <= 6'd0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= 6'd0;
            exc_q <= 5'd0;
            epc_q <= 32'd0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Table-driven, scoreboarded bench for cp0_unit with hand-written reset sequences.
module tb_cp0_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  A1, A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] pc_in;
    logic        bd_in;
    logic [4:0]  excCode_in;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        req;
    logic [31:0] EPC_out;
    logic [31:0] DOut;

    cp0_unit dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
        .pc_in(pc_in), .bd_in(bd_in), .excCode_in(excCode_in), .HWInt(HWInt),
        .EXLClr(EXLClr), .req(req), .EPC_out(EPC_out), .DOut(DOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] din;
        logic        we;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        clr;
        logic        e_req;
        logic [31:0] e_dout;
        logic [31:0] e_epc;
    } vec_t;

    typedef struct {
        int          idx;
        logic        e_req;
        logic [31:0] e_dout;
        logic [31:0] e_epc;
    } exp_t;

    localparam int NV = 34;
    vec_t vecs [NV];
    exp_t sb [$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic vec_t mk(input logic [4:0] a1, input logic [4:0] a2,
                                input logic [31:0] din, input logic we,
                                input logic [31:0] pc, input logic bd,
                                input logic [4:0] exc, input logic [5:0] hw,
                                input logic clr, input logic e_req,
                                input logic [31:0] e_dout, input logic [31:0] e_epc);
        vec_t v;
        v.a1 = a1; v.a2 = a2; v.din = din; v.we = we; v.pc = pc; v.bd = bd;
        v.exc = exc; v.hw = hw; v.clr = clr;
        v.e_req = e_req; v.e_dout = e_dout; v.e_epc = e_epc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        //              a1     a2     din            we    pc             bd    exc    hw        clr   req   dout           epc
        vecs[0]  = mk(5'd12, 5'd12, 32'h0000_0401, 1'b1, 32'h0,         1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
        vecs[1]  = mk(5'd12, 5'd0,  32'h0,         1'b0, 32'h0000_3008, 1'b0, 5'd0,  6'b000001, 1'b0, 1'b1, 32'h0000_0401, 32'h0000_0000);
        vecs[2]  = mk(5'd13, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 5'd0,  6'b000001, 1'b0, 1'b0, 32'h0000_0400, 32'h0000_3008);
        vecs[3]  = mk(5'd12, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 5'd0,  6'b000001, 1'b0, 1'b0, 32'h0000_0403, 32'h0000_3008);
        vecs[4]  = mk(5'd13, 5'd0,  32'h0,         1'b0, 32'h0000_5000, 1'b0, 5'd4,  6'b000011, 1'b0, 1'b0, 32'h0000_0400, 32'h0000_3008);
        vecs[5]  = mk(5'd13, 5'd0,  32'h0,         1'b0, 32'h0000_5000, 1'b0, 5'd4,  6'b100000, 1'b0, 1'b0, 32'h0000_0C00, 32'h0000_3008);
        vecs[6]  = mk(5'd13, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 5'd0,  6'b000001, 1'b0, 1'b0, 32'h0000_8000, 32'h0000_3008);
        vecs[7]  = mk(5'd12, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 5'd0,  6'b000001, 1'b1, 1'b0, 32'h0000_0403, 32'h0000_3008);
        vecs[8]  = mk(5'd12, 5'd0,  32'h0,         1'b0, 32'h0000_3200, 1'b0, 5'd0,  6'b000001, 1'b0, 1'b1, 32'h0000_0401, 32'h0000_3008);
        vecs[9]  = mk(5'd14, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_3200, 32'h0000_3200);
        vecs[10] = mk(5'd12, 5'd12, 32'h0000_0802, 1'b1, 32'h0,         1'b0, 5'd0,  6'b000000, 1'b1, 1'b0, 32'h0000_0403, 32'h0000_3200);
        vecs[11] = mk(5'd12, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_0800, 32'h0000_3200);
        vecs[12] = mk(5'd13, 5'd0,  32'h0,         1'b0, 32'h0000_3100, 1'b1, 5'd12, 6'b000000, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_3200);
        vecs[13] = mk(5'd13, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h8000_0030, 32'h0000_30FC);
        vecs[14] = mk(5'd14, 5'd12, 32'h0000_0401, 1'b1, 32'h0,         1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_30FC, 32'h0000_30FC);
        vecs[15] = mk(5'd12, 5'd14, 32'h0000_4000, 1'b1, 32'h0000_3300, 1'b0, 5'd10, 6'b000000, 1'b0, 1'b1, 32'h0000_0401, 32'h0000_30FC);
        vecs[16] = mk(5'd13, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_0028, 32'h0000_3300);
        vecs[17] = mk(5'd14, 5'd12, 32'h0000_0401, 1'b1, 32'h0,         1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_3300, 32'h0000_3300);
        vecs[18] = mk(5'd12, 5'd0,  32'h0,         1'b0, 32'h0000_3400, 1'b1, 5'd12, 6'b000001, 1'b0, 1'b1, 32'h0000_0401, 32'h0000_3300);
        vecs[19] = mk(5'd13, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h8000_0400, 32'h0000_33FC);
        vecs[20] = mk(5'd13, 5'd13, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_33FC);
        vecs[21] = mk(5'd13, 5'd15, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_33FC);
        vecs[22] = mk(5'd15, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_2024, 32'h0000_33FC);
        vecs[23] = mk(5'd7,  5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_33FC);
        vecs[24] = mk(5'd12, 5'd12, 32'h0000_0400, 1'b1, 32'h0,         1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_0403, 32'h0000_33FC);
        vecs[25] = mk(5'd12, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 5'd0,  6'b000001, 1'b0, 1'b0, 32'h0000_0400, 32'h0000_33FC);
        vecs[26] = mk(5'd12, 5'd12, 32'h0000_0401, 1'b1, 32'h0,         1'b0, 5'd0,  6'b000001, 1'b0, 1'b0, 32'h0000_0400, 32'h0000_33FC);
        vecs[27] = mk(5'd12, 5'd0,  32'h0,         1'b0, 32'h0000_3500, 1'b0, 5'd0,  6'b000001, 1'b0, 1'b1, 32'h0000_0401, 32'h0000_33FC);
        vecs[28] = mk(5'd14, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_3500, 32'h0000_3500);
        vecs[29] = mk(5'd14, 5'd14, 32'h1234_5678, 1'b1, 32'h0,         1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_3500, 32'h0000_3500);
        vecs[30] = mk(5'd14, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h1234_5678, 32'h1234_5678);
        vecs[31] = mk(5'd1,  5'd12, 32'h0000_0000, 1'b1, 32'h0,         1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_0000, 32'h1234_5678);
        vecs[32] = mk(5'd0,  5'd0,  32'h0,         1'b0, 32'h0,         1'b1, 5'd4,  6'b000000, 1'b0, 1'b1, 32'h0000_0000, 32'h1234_5678);
        vecs[33] = mk(5'd14, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);

        reset = 1'b1; A1 = 5'd12; A2 = 5'd0; DIn = 32'd0; WE = 1'b0; pc_in = 32'd0;
        bd_in = 1'b0; excCode_in = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
        @(negedge clk);
        check("reset_req", {31'd0, req}, 32'd0);
        check("reset_sr", DOut, 32'd0);
        check("reset_epc", EPC_out, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            A1 = vecs[i].a1; A2 = vecs[i].a2; DIn = vecs[i].din; WE = vecs[i].we;
            pc_in = vecs[i].pc; bd_in = vecs[i].bd; excCode_in = vecs[i].exc;
            HWInt = vecs[i].hw; EXLClr = vecs[i].clr;
            e.idx = i; e.e_req = vecs[i].e_req; e.e_dout = vecs[i].e_dout; e.e_epc = vecs[i].e_epc;
            sb.push_back(e);
            @(negedge clk);
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL scoreboard_empty: got 0 entries, expected 1 at vector %0d", i);
            end else begin
                e = sb.pop_front();
                check($sformatf("v%0d_req", e.idx), {31'd0, req}, {31'd0, e.e_req});
                check($sformatf("v%0d_dout", e.idx), DOut, e.e_dout);
                check($sformatf("v%0d_epc", e.idx), EPC_out, e.e_epc);
            end
        end

        // Reset asserted mid-cycle must clear state without a clock edge.
        @(posedge clk); #1;
        A1 = 5'd12; WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01;
        excCode_in = 5'd0; HWInt = 6'd0; bd_in = 1'b0; pc_in = 32'd0; EXLClr = 1'b0;
        @(posedge clk); #1;
        A2 = 5'd14; DIn = 32'h0000_3010;
        @(posedge clk); #1;
        WE = 1'b0; A2 = 5'd0; DIn = 32'd0;
        #1;
        check("pre_reset_sr", DOut, 32'h0000_FC01);
        check("pre_reset_epc", EPC_out, 32'h0000_3010);
        excCode_in = 5'd4;
        #1;
        check("pre_reset_req", {31'd0, req}, 32'd1);
        reset = 1'b1;
        #1;
        check("midreset_sr", DOut, 32'd0);
        check("midreset_epc", EPC_out, 32'd0);
        check("midreset_req", {31'd0, req}, 32'd0);
        @(posedge clk); #1;
        excCode_in = 5'd0;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_sr", DOut, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
